bf16_fma_wb_buffer: RTL and testbench
=====================================

Name: bf16_fma_wb_buffer

Overview:
- Downstream writeback stage for bf16_fma; captures each issued result together with its four exception flags.
- Entries are held in a small FIFO and drained by the consumer through a valid/ready handshake.
- The FMA cannot be stalled, so the block also keeps accumulated sticky exception flags and a counter of results dropped because the buffer was full.
- Sits between bf16_fma and the register-file/writeback port of the accelerator.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- DROP_W, 8, width of the saturating dropped-result counter.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  bf16_fma result valid this cycle
- in_result  input  16  bf16 result from bf16_fma
- in_invalid  input  1  invalid flag from bf16_fma
- in_overflow  input  1  overflow flag from bf16_fma
- in_underflow  input  1  underflow flag from bf16_fma
- in_inexact  input  1  inexact flag from bf16_fma
- in_ready  output  1  buffer can accept an entry; informational only, since upstream does not stall
- out_valid  output  1  head entry available
- out_result  output  16  head entry result
- out_flags  output  4  head entry flags as {invalid, overflow, underflow, inexact}
- out_ready  input  1  consumer accepts the head entry
- fflags  output  4  sticky OR of all accepted flags, same bit order as out_flags
- fflags_clr  input  1  clears fflags
- count  output  $clog2(DEPTH)+1  number of occupied entries
- drop_cnt  output  DROP_W  saturating count of dropped results

Behaviour:
- Reset is synchronous and sampled on the rising clk edge. In the cycle after reset is asserted:
  - count=0, out_valid=0, in_ready=1;
  - out_result=16'h0000, out_flags=4'h0;
  - fflags=4'h0, drop_cnt=0;
  - read and write pointers at 0.
- Asserting reset mid-operation discards all entries; no pop is reported in that cycle.
- Storage: DEPTH entries of 20 bits ({flags, result}). Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Full/empty: in_ready = (count != DEPTH); out_valid = (count != 0).
- Push = in_valid & in_ready; pop = out_valid & out_ready. Both are registered at the clk edge.
- out_result and out_flags show the head entry combinationally from storage.
  - When empty they must read 0 (a registered or muxed zero is acceptable).
- Latency:
  - A result pushed at edge N is visible on out_* with out_valid=1 after edge N.
  - There is no same-cycle bypass from input to output.
- Simultaneous push and pop:
  - When 0 < count < DEPTH: both occur and count is unchanged.
  - When full: in_ready=0, so the push is refused even if a pop occurs in the same cycle.
  - When empty: out_valid=0, so no pop occurs; the push occurs.
- Drop: when in_valid=1 and in_ready=0, the entry is discarded and drop_cnt increments by 1.
  - drop_cnt saturates at 2^DROP_W-1.
  - Flags of a dropped result still OR into fflags, so exception status is never lost.
- Sticky flags: on any cycle with in_valid=1, fflags_next = (fflags_clr ? 4'h0 : fflags) | in_flags.
  - When fflags_clr and in_valid coincide, the clear applies to the old value and the new flags are set.
  - fflags_clr has no effect on FIFO contents or on drop_cnt.
- count is updated as +1 (push only), -1 (pop only), or unchanged. It never exceeds DEPTH and never underflows.
- out_valid must not deassert without a pop or a reset.
- The head entry must remain stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: BF16_WB_NAN_CANON_EN.
- When defined: on push, any in_result with exponent 8'hFF and mantissa != 0 is stored as the canonical quiet NaN 16'h7FC0. Flags are stored unchanged.
- When undefined: in_result is stored bit-exact.
- Infinities (16'h7F80 and 16'hFF80) are stored unchanged in both configurations.

Test Plan:
- Reset, then push 16'h40E0 with flags 0 and hold out_ready=0 → after one edge out_valid=1, out_result=16'h40E0, count=1; entry holds stable while out_ready stays low.
- Push 5 results (16'h3F80, 16'h4000, 16'h4040, 16'h4080, 16'h40A0) with DEPTH=4 and out_ready=0 → count=4, in_ready=0, drop_cnt=1; draining returns the first four in order and count returns to 0.
- Continuous streaming with in_valid=1 and out_ready=1 for 10 cycles (pointers wrap twice) → count stays at 1, output order matches input order, drop_cnt=0.
- Push 16'h7F80 with in_overflow=1, then 16'h0000 with in_underflow=1 and in_inexact=1 → fflags=4'b0111. Then fflags_clr=1 together with a push of in_invalid=1 → fflags=4'b1000.
- Push 16'h7FA1 → out_result=16'h7FC0 with BF16_WB_NAN_CANON_EN defined, 16'h7FA1 without. Push 16'hFF80 → 16'hFF80 in both configurations.
- Fill to count=3, then assert reset for one cycle while in_valid=1 and out_ready=1 → count=0, out_valid=0, fflags=0, drop_cnt=0, and the concurrent push is not stored.

Source files
------------

// File: rtl/bf16_fma_wb_buffer.sv
// bf16_fma_wb_buffer: writeback FIFO for bf16_fma results with sticky flags and drop counter; BF16_WB_NAN_CANON_EN canonicalises stored NaNs
module bf16_fma_wb_buffer #(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [15:0]              in_result,
  input  logic                     in_invalid,
  input  logic                     in_overflow,
  input  logic                     in_underflow,
  input  logic                     in_inexact,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [15:0]              out_result,
  output logic [3:0]               out_flags,
  input  logic                     out_ready,
  output logic [3:0]               fflags,
  input  logic                     fflags_clr,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DROP_W-1:0]        drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [19:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [3:0]    in_flags;
  logic [15:0]   wr_result;
  logic          push, pop;
  assign in_flags  = {in_invalid, in_overflow, in_underflow, in_inexact};
`ifdef BF16_WB_NAN_CANON_EN
  assign wr_result = (in_result[14:7] == 8'hFF && in_result[6:0] != 7'd0) ? 16'h7FC0 : in_result;
`else
  assign wr_result = in_result;
`endif
  assign in_ready   = count != (AW+1)'(DEPTH);
  assign out_valid  = count != '0;
  assign push       = in_valid & in_ready;
  assign pop        = out_valid & out_ready;
  assign out_result = out_valid ? mem[rd_ptr][15:0] : 16'h0000;
  assign out_flags  = out_valid ? mem[rd_ptr][19:16] : 4'h0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {in_flags, wr_result};
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      fflags   <= 4'h0;
      drop_cnt <= '0;
    end else begin
      wr_ptr   <= wr_ptr + AW'(push);
      rd_ptr   <= rd_ptr + AW'(pop);
      count    <= count + (AW+1)'(push) - (AW+1)'(pop);
      fflags   <= in_valid ? ((fflags_clr ? 4'h0 : fflags) | in_flags) : (fflags_clr ? 4'h0 : fflags);
      drop_cnt <= (in_valid && !in_ready && drop_cnt != '1) ? drop_cnt + 1'b1 : drop_cnt;
    end
  end
endmodule

// File: tb/tb_bf16_fma_wb_buffer.sv
// tb_bf16_fma_wb_buffer: directed self-checking bench for bf16_fma_wb_buffer
module tb_bf16_fma_wb_buffer;
  logic        clk = 0;
  logic        reset = 0;
  logic        in_valid = 0;
  logic [15:0] in_result = '0;
  logic        in_invalid = 0, in_overflow = 0, in_underflow = 0, in_inexact = 0;
  logic        in_ready, out_valid, out_ready = 0, fflags_clr = 0;
  logic [15:0] out_result;
  logic [3:0]  out_flags, fflags;
  logic [2:0]  count;
  logic [7:0]  drop_cnt;
  logic [15:0] vals [5] = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080, 16'h40A0};
  logic [15:0] nan_exp;
  int n_checks = 0, n_fail = 0;
  bf16_fma_wb_buffer #(.DEPTH(4), .DROP_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_result(in_result),
    .in_invalid(in_invalid), .in_overflow(in_overflow), .in_underflow(in_underflow),
    .in_inexact(in_inexact), .in_ready(in_ready), .out_valid(out_valid),
    .out_result(out_result), .out_flags(out_flags), .out_ready(out_ready),
    .fflags(fflags), .fflags_clr(fflags_clr), .count(count), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_in(input logic v, input logic [15:0] r, input logic [3:0] f);
    in_valid = v;
    in_result = r;
    {in_invalid, in_overflow, in_underflow, in_inexact} = f;
  endtask
  task automatic push(input logic [15:0] r, input logic [3:0] f);
    set_in(1, r, f);
    tick;
    set_in(0, 16'h0, 4'h0);
  endtask
  task automatic do_reset;
    reset = 1;
    set_in(0, 16'h0, 4'h0);
    out_ready = 0;
    fflags_clr = 0;
    tick;
    reset = 0;
  endtask
  initial begin
    do_reset;
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_result", out_result, 0);
    check("rst_out_flags", out_flags, 0);
    check("rst_fflags", fflags, 0);
    check("rst_drop", drop_cnt, 0);
    push(16'h40E0, 4'h0);
    check("t1_valid", out_valid, 1);
    check("t1_result", out_result, 16'h40E0);
    check("t1_count", count, 1);
    tick;
    tick;
    check("t1_hold_result", out_result, 16'h40E0);
    check("t1_hold_valid", out_valid, 1);
    out_ready = 1;
    tick;
    out_ready = 0;
    check("t1_pop_count", count, 0);
    for (int i = 0; i < 5; i++) push(vals[i], 4'h0);
    check("t2_count", count, 4);
    check("t2_in_ready", in_ready, 0);
    check("t2_drop", drop_cnt, 1);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_drain%0d", i), out_result, vals[i]);
      tick;
    end
    out_ready = 0;
    check("t2_empty_count", count, 0);
    check("t2_empty_valid", out_valid, 0);
    do_reset;
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      set_in(1, 16'h1000 + 16'(i), 4'h0);
      tick;
      check($sformatf("t3_count%0d", i), count, 1);
      check($sformatf("t3_order%0d", i), out_result, 16'h1000 + 16'(i));
    end
    set_in(0, 16'h0, 4'h0);
    tick;
    out_ready = 0;
    check("t3_final_count", count, 0);
    check("t3_drop", drop_cnt, 0);
    push(16'h7F80, 4'b0100);
    push(16'h0000, 4'b0011);
    check("t4_fflags", fflags, 4'b0111);
    check("t4_head_flags", out_flags, 4'b0100);
    fflags_clr = 1;
    push(16'h3F80, 4'b1000);
    fflags_clr = 0;
    check("t4_clr_set", fflags, 4'b1000);
    check("t4_count", count, 3);
    fflags_clr = 1;
    tick;
    fflags_clr = 0;
    check("t4_clr_only", fflags, 4'b0000);
    check("t4_clr_keeps_fifo", count, 3);
    do_reset;
`ifdef BF16_WB_NAN_CANON_EN
    nan_exp = 16'h7FC0;
`else
    nan_exp = 16'h7FA1;
`endif
    push(16'h7FA1, 4'h0);
    check("t5_nan", out_result, nan_exp);
    out_ready = 1;
    tick;
    out_ready = 0;
    push(16'hFF80, 4'h0);
    check("t5_inf", out_result, 16'hFF80);
    do_reset;
    for (int i = 0; i < 3; i++) push(vals[i], 4'b0001);
    check("t6_fill", count, 3);
    check("t6_fflags", fflags, 4'b0001);
    reset = 1;
    set_in(1, 16'h4321, 4'b1000);
    out_ready = 1;
    tick;
    reset = 0;
    set_in(0, 16'h0, 4'h0);
    out_ready = 0;
    check("t6_count", count, 0);
    check("t6_valid", out_valid, 0);
    check("t6_fflags_rst", fflags, 0);
    check("t6_drop", drop_cnt, 0);
    tick;
    check("t6_no_store", count, 0);
    for (int i = 0; i < 4; i++) push(vals[i], 4'h0);
    set_in(1, 16'h1234, 4'h0);
    for (int i = 0; i < 300; i++) tick;
    set_in(0, 16'h0, 4'h0);
    check("t7_drop_sat", drop_cnt, 8'hFF);
    check("t7_head", out_result, vals[0]);
    do_reset;
    check("t7_drop_rst", drop_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
